// File: rtl/instr_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_prefetch_pkg
// Shared types and constants for the instruction prefetch buffer.
//   FETCH_ADDR_WIDTH : byte-address width of the instruction memory port
//   FETCH_DATA_WIDTH : instruction word width
//   WORD_BYTES       : byte stride between consecutive instruction words
//   fetch_entry_t    : one buffered instruction, {addr, data}
// -----------------------------------------------------------------------------
package instr_prefetch_pkg;

    localparam int FETCH_ADDR_WIDTH = 16;
    localparam int FETCH_DATA_WIDTH = 32;
    localparam int WORD_BYTES       = FETCH_DATA_WIDTH / 8;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] addr;
        logic [FETCH_DATA_WIDTH-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_buf_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
// Small synchronous-write FIFO of fetch_entry_t. The head is read straight out
// of the storage registers, so a word pushed this cycle is visible next cycle
// at the earliest (no fall-through).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : drop all entries (wins over push/pop)
//   push, entry : write entry at the tail
//   pop         : advance the head (caller guarantees count != 0)
//   count       : number of valid entries, 0..DEPTH
//   head        : entry at the read pointer
// -----------------------------------------------------------------------------
module prefetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               entry,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    // NOTE: storage is reset too, so the head reads as all-zero out of reset
    // instead of X; the memory is tiny, so flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge values regardless of statement order.
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_buf.sv
// -----------------------------------------------------------------------------
// instr_prefetch_buf
// Walks a fetch PC, issues single-word reads to a fixed one-cycle-latency
// instruction memory, buffers returned words with their address and presents
// them to the core as a valid/ready stream. A branch flushes the buffer and
// discards the in-flight read. The memory-side write enable and byte enables
// are tied off outside this block; it only reads.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   enable_i          : allow new reads
//   branch_i          : one-cycle redirect strobe, branch_addr_i = target
//   instr_valid_o/instr_rdata_o/instr_addr_o/instr_ready_i : core stream
//   mem_en_o/mem_addr_o/mem_rdata_i : instruction memory read port
// Parameters ADDR_WIDTH/DATA_WIDTH must match the package entry type widths.
// -----------------------------------------------------------------------------
module instr_prefetch_buf
    import instr_prefetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_ready_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] inflight_addr_q;

    logic [CW-1:0]         count;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CW:0]           occupancy;

    // A pop implies count >= 1, so the subtraction never underflows.
    assign pop       = instr_valid_o & instr_ready_i & ~branch_i;
    assign push      = inflight_q & ~branch_i;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

    // Credit check reserves a slot for every read still in flight, so the
    // FIFO can never overflow. Gated by rst so mem_en_o is low during reset.
    assign issue = ~rst & enable_i & ~branch_i & (occupancy < (CW+1)'(DEPTH));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        push_entry      = '0;
        push_entry.addr = inflight_addr_q;
        push_entry.data = mem_rdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q            <= BOOT_ADDR;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            inflight_q <= issue;
            if (branch_i) begin
                pc_q <= branch_addr_i & ~ADDR_WIDTH'(WORD_BYTES - 1);
            end else if (issue) begin
                pc_q            <= pc_q + ADDR_WIDTH'(WORD_BYTES);
                inflight_addr_q <= pc_q;
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_i),
        .push  (push),
        .entry (push_entry),
        .pop   (pop),
        .count (count),
        .head  (head)
    );

    assign mem_en_o      = issue;
    assign mem_addr_o    = pc_q;
    assign instr_valid_o = (count != '0);
    assign instr_rdata_o = head.data;
    assign instr_addr_o  = head.addr;

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_buf
// Directed bench for instr_prefetch_buf (ADDR_WIDTH=16, DATA_WIDTH=32,
// DEPTH=4, BOOT_ADDR=0). A one-cycle-latency memory model returns
// mem_word(addr). Inputs change 1 ns after the rising edge; outputs are
// compared 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        branch_i;
    logic [15:0] branch_addr_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [15:0] instr_addr_o;
    logic        instr_ready_i;
    logic        mem_en_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_rdata_i = '0;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_prefetch_buf #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .BOOT_ADDR  (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .instr_valid_o (instr_valid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_addr_o  (instr_addr_o),
        .instr_ready_i (instr_ready_i),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // Instruction memory model: fixed one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en_o) mem_rdata_i <= mem_word(mem_addr_o);
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two cycles, then release with the given controls; returns
    // inside cycle C0 (the first cycle after release), outputs settled.
    task automatic do_reset(input logic en, input logic rdy);
        rst = 1'b1; enable_i = 1'b0; branch_i = 1'b0;
        branch_addr_i = '0; instr_ready_i = 1'b0;
        adv(); adv();
        rst = 1'b0; enable_i = en; instr_ready_i = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable_i = 1'b1; instr_ready_i = 1'b1;
        branch_i = 1'b0; branch_addr_i = '0;
        adv(); #1;
        vectors++;
        if (mem_en_o !== 1'b0 || mem_addr_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mem: en=%b addr=%h, required en=0 addr=0000", mem_en_o, mem_addr_o);
        end
        vectors++;
        if (instr_valid_o !== 1'b0 || instr_addr_o !== 16'h0 || instr_rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_head: valid=%b addr=%h data=%h, required 0/0000/00000000",
                     instr_valid_o, instr_addr_o, instr_rdata_o);
        end
    endtask

    task automatic test_sequential();
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) begin adv(); #1; end
            vectors++;
            if (mem_en_o !== 1'b1 || mem_addr_o !== 16'(4 * k)) begin
                miscompares++;
                $display("FAIL seq_issue c%0d: en=%b addr=%h, required en=1 addr=%h",
                         k, mem_en_o, mem_addr_o, 16'(4 * k));
            end
            vectors++;
            if (k < 2) begin
                if (instr_valid_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL seq_valid c%0d: valid=%b, required 0", k, instr_valid_o);
                end
            end else if (instr_valid_o !== 1'b1 || instr_addr_o !== 16'(4 * (k - 2)) ||
                         instr_rdata_o !== mem_word(16'(4 * (k - 2)))) begin
                miscompares++;
                $display("FAIL seq_head c%0d: valid=%b addr=%h data=%h, required 1 %h %h",
                         k, instr_valid_o, instr_addr_o, instr_rdata_o,
                         16'(4 * (k - 2)), mem_word(16'(4 * (k - 2))));
            end
        end
    endtask

    task automatic test_backpressure();
        int issues;
        do_reset(1'b1, 1'b0);
        issues = 0;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) begin adv(); #1; end
            if (mem_en_o === 1'b1) issues++;
        end
        vectors++;
        if (issues != 4) begin
            miscompares++;
            $display("FAIL bp_issue_count: issues=%0d, required 4", issues);
        end
        vectors++;
        if (mem_en_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_addr_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL bp_stall: en=%b valid=%b head=%h, required en=0 valid=1 head=0000",
                     mem_en_o, instr_valid_o, instr_addr_o);
        end
        adv(); instr_ready_i = 1'b1; #1;
        vectors++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== 16'h0010 || instr_addr_o !== 16'h0000 ||
            instr_rdata_o !== mem_word(16'h0000)) begin
            miscompares++;
            $display("FAIL bp_resume: en=%b addr=%h head=%h data=%h, required 1 0010 0000 %h",
                     mem_en_o, mem_addr_o, instr_addr_o, instr_rdata_o, mem_word(16'h0000));
        end
        adv(); #1;
        vectors++;
        if (instr_valid_o !== 1'b1 || instr_addr_o !== 16'h0004) begin
            miscompares++;
            $display("FAIL bp_second: valid=%b head=%h, required 1 0004", instr_valid_o, instr_addr_o);
        end
    endtask

    task automatic test_branch();
        // C4 with ready low: 3 words buffered, read of 0x000C in flight.
        do_reset(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) adv();
        branch_i = 1'b1; branch_addr_i = 16'h0806; instr_ready_i = 1'b1; #1;
        vectors++;
        if (mem_en_o !== 1'b0 || instr_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL br_cycle: en=%b valid=%b, required en=0 valid=1", mem_en_o, instr_valid_o);
        end
        adv(); branch_i = 1'b0; #1;
        vectors++;
        if (instr_valid_o !== 1'b0 || mem_en_o !== 1'b1 || mem_addr_o !== 16'h0804) begin
            miscompares++;
            $display("FAIL br_flush: valid=%b en=%b addr=%h, required 0 1 0804",
                     instr_valid_o, mem_en_o, mem_addr_o);
        end
        adv(); #1;
        vectors++;
        if (instr_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL br_no_stale: valid=%b head=%h, required valid=0", instr_valid_o, instr_addr_o);
        end
        adv(); #1;
        vectors++;
        if (instr_valid_o !== 1'b1 || instr_addr_o !== 16'h0804 || instr_rdata_o !== mem_word(16'h0804)) begin
            miscompares++;
            $display("FAIL br_target: valid=%b addr=%h data=%h, required 1 0804 %h",
                     instr_valid_o, instr_addr_o, instr_rdata_o, mem_word(16'h0804));
        end
        adv(); #1;
        vectors++;
        if (instr_valid_o !== 1'b1 || instr_addr_o !== 16'h0808) begin
            miscompares++;
            $display("FAIL br_next: valid=%b addr=%h, required 1 0808", instr_valid_o, instr_addr_o);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 1'b1);
        adv(); branch_i = 1'b1; branch_addr_i = 16'hFFFC; #1;
        adv(); branch_i = 1'b0; #1;
        vectors++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== 16'hFFFC) begin
            miscompares++;
            $display("FAIL wrap_first: en=%b addr=%h, required 1 FFFC", mem_en_o, mem_addr_o);
        end
        adv(); #1;
        vectors++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_second: en=%b addr=%h, required 1 0000", mem_en_o, mem_addr_o);
        end
        adv(); #1;
        vectors++;
        if (instr_valid_o !== 1'b1 || instr_addr_o !== 16'hFFFC || instr_rdata_o !== mem_word(16'hFFFC)) begin
            miscompares++;
            $display("FAIL wrap_head0: valid=%b addr=%h data=%h, required 1 FFFC %h",
                     instr_valid_o, instr_addr_o, instr_rdata_o, mem_word(16'hFFFC));
        end
        adv(); #1;
        vectors++;
        if (instr_valid_o !== 1'b1 || instr_addr_o !== 16'h0000 || instr_rdata_o !== mem_word(16'h0000)) begin
            miscompares++;
            $display("FAIL wrap_head1: valid=%b addr=%h data=%h, required 1 0000 %h",
                     instr_valid_o, instr_addr_o, instr_rdata_o, mem_word(16'h0000));
        end
    endtask

    task automatic test_enable_drop();
        do_reset(1'b1, 1'b1);
        adv(); enable_i = 1'b0; #1;
        vectors++;
        if (mem_en_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL en_drop: en=%b valid=%b, required 0 0", mem_en_o, instr_valid_o);
        end
        adv(); #1;
        vectors++;
        if (instr_valid_o !== 1'b1 || instr_addr_o !== 16'h0000 || mem_en_o !== 1'b0) begin
            miscompares++;
            $display("FAIL en_deliver: valid=%b addr=%h en=%b, required 1 0000 0",
                     instr_valid_o, instr_addr_o, mem_en_o);
        end
        adv(); #1;
        vectors++;
        if (instr_valid_o !== 1'b0 || mem_en_o !== 1'b0) begin
            miscompares++;
            $display("FAIL en_idle: valid=%b en=%b, required 0 0", instr_valid_o, mem_en_o);
        end
    endtask

    task automatic test_reset_midop();
        // C3 with ready low: 2 words buffered, read of 0x0008 in flight.
        do_reset(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) adv();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (instr_valid_o !== 1'b0 || instr_addr_o !== 16'h0 || instr_rdata_o !== 32'h0 ||
            mem_en_o !== 1'b0 || mem_addr_o !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_async: valid=%b addr=%h data=%h en=%b maddr=%h, required all 0",
                     instr_valid_o, instr_addr_o, instr_rdata_o, mem_en_o, mem_addr_o);
        end
        adv(); rst = 1'b0; #1;
        vectors++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_restart: en=%b addr=%h, required 1 0000", mem_en_o, mem_addr_o);
        end
        adv(); adv(); #1;
        vectors++;
        if (instr_valid_o !== 1'b1 || instr_addr_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_first_word: valid=%b addr=%h, required 1 0000", instr_valid_o, instr_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_wrap();
        test_enable_drop();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
